// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode groups and flag-validity rules.
package alu_pkg;

  localparam int W   = 32;
  localparam int OPW = 4;

  // ALUC[3:2] operation groups
  localparam logic [1:0] ADD_SUB = 2'b00;
  localparam logic [1:0] LOGIC   = 2'b01;
  localparam logic [1:0] LUI_SLT = 2'b10;
  localparam logic [1:0] SHIFT   = 2'b11;

  localparam logic [3:0] SLTU = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Carry is meaningful for unsigned add/sub, SLTU and the shift group.
  function automatic logic carry_valid(input logic [3:0] aluc);
    return (aluc[3:1] == 3'b000) || (aluc == SLTU) || (aluc[3:2] == SHIFT);
  endfunction

  // Overflow is meaningful only for signed add/sub.
  function automatic logic overflow_valid(input logic [3:0] aluc);
    return (aluc[3:2] == ADD_SUB) && aluc[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; pointer names the winner when both request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr;

  // Single requester wins outright; a tie goes to the pointed port.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After any accepted grant, the other port gets priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ptr <= 1'b0;
    else if (take && |req)    ptr <= ~gnt[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and
// owns the architectural Z/C/N/V flag register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W   = alu_pkg::W,
  parameter int OPW = alu_pkg::OPW
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           REQ0_VALID,
  output logic           REQ0_READY,
  input  logic [W-1:0]   REQ0_A,
  input  logic [W-1:0]   REQ0_B,
  input  logic [OPW-1:0] REQ0_ALUC,
  input  logic           REQ1_VALID,
  output logic           REQ1_READY,
  input  logic [W-1:0]   REQ1_A,
  input  logic [W-1:0]   REQ1_B,
  input  logic [OPW-1:0] REQ1_ALUC,
  output logic           RSP0_VALID,
  input  logic           RSP0_READY,
  output logic           RSP1_VALID,
  input  logic           RSP1_READY,
  output logic [W-1:0]   RSP_RESULT,
  output logic [3:0]     RSP_FLAGS,
  output logic [W-1:0]   ALU_A,
  output logic [W-1:0]   ALU_B,
  output logic [OPW-1:0] ALU_ALUC,
  input  logic [W-1:0]   ALU_RESULT,
  input  logic           ALU_ZERO,
  input  logic           ALU_CARRY,
  input  logic           ALU_NEGATIVE,
  input  logic           ALU_OVERFLOW,
  output logic           FLAG_Z,
  output logic           FLAG_C,
  output logic           FLAG_N,
  output logic           FLAG_V,
  output logic           BUSY
);

  arb_state_t     state, state_nxt;
  logic [1:0]     gnt;
  logic           idle, accept, owner, rsp_take;
  logic [W-1:0]   op_a, op_b;
  logic [OPW-1:0] op_c;
  logic           c_nxt, v_nxt;

  assign idle   = (state == IDLE);
  assign accept = idle && (|gnt);

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   ({REQ1_VALID, REQ0_VALID}),
    .take  (idle),
    .gnt   (gnt)
  );

  // Ready is qualified by reset so nothing looks accepted while held in reset.
  assign REQ0_READY = RST_N && idle && gnt[0];
  assign REQ1_READY = RST_N && idle && gnt[1];

  assign RSP0_VALID = (state == RESP) && !owner;
  assign RSP1_VALID = (state == RESP) &&  owner;
  assign rsp_take   = owner ? RSP1_READY : RSP0_READY;
  assign BUSY       = !idle;

  assign ALU_A    = op_a;
  assign ALU_B    = op_b;
  assign ALU_ALUC = op_c;

  // C and V only take the ALU value when the current opcode defines them.
  assign c_nxt = carry_valid(4'(op_c))    ? ALU_CARRY    : FLAG_C;
  assign v_nxt = overflow_valid(4'(op_c)) ? ALU_OVERFLOW : FLAG_V;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Latch the granted request; operands keep driving the ALU afterwards.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      owner <= 1'b0;
    end else if (accept) begin
      owner <= gnt[1];
      op_a  <= gnt[1] ? REQ1_A    : REQ0_A;
      op_b  <= gnt[1] ? REQ1_B    : REQ0_B;
      op_c  <= gnt[1] ? REQ1_ALUC : REQ0_ALUC;
    end
  end

  // Capture ALU result and update flags at the end of EXEC.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RSP_RESULT <= '0;
      RSP_FLAGS  <= '0;
      FLAG_Z     <= 1'b0;
      FLAG_C     <= 1'b0;
      FLAG_N     <= 1'b0;
      FLAG_V     <= 1'b0;
    end else if (state == EXEC) begin
      RSP_RESULT <= ALU_RESULT;
      RSP_FLAGS  <= {ALU_ZERO, c_nxt, ALU_NEGATIVE, v_nxt};
      FLAG_Z     <= ALU_ZERO;
      FLAG_C     <= c_nxt;
      FLAG_N     <= ALU_NEGATIVE;
      FLAG_V     <= v_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]  REQ0_ALUC, REQ1_ALUC;
  logic        RSP0_VALID, RSP0_READY, RSP1_VALID, RSP1_READY;
  logic [31:0] RSP_RESULT;
  logic [3:0]  RSP_FLAGS;
  logic [31:0] ALU_A, ALU_B, ALU_RESULT;
  logic [3:0]  ALU_ALUC;
  logic        ALU_ZERO, ALU_CARRY, ALU_NEGATIVE, ALU_OVERFLOW;
  logic        FLAG_Z, FLAG_C, FLAG_N, FLAG_V, BUSY;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  alu_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_ALUC(REQ0_ALUC),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_ALUC(REQ1_ALUC),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_FLAGS(RSP_FLAGS),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_ALUC(ALU_ALUC), .ALU_RESULT(ALU_RESULT),
    .ALU_ZERO(ALU_ZERO), .ALU_CARRY(ALU_CARRY), .ALU_NEGATIVE(ALU_NEGATIVE), .ALU_OVERFLOW(ALU_OVERFLOW),
    .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C), .FLAG_N(FLAG_N), .FLAG_V(FLAG_V), .BUSY(BUSY)
  );

  // Behavioural ALU; carry/overflow are 0 outside add/sub so held flags show.
  logic [32:0] sum;
  always_comb begin
    sum          = '0;
    ALU_RESULT   = '0;
    ALU_CARRY    = 1'b0;
    ALU_OVERFLOW = 1'b0;
    case (ALU_ALUC)
      4'b0000, 4'b0010: sum = {1'b0, ALU_A} + {1'b0, ALU_B};
      4'b0001, 4'b0011: sum = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 33'd1;
      4'b0100: sum = {1'b0, ALU_A & ALU_B};
      4'b0101: sum = {1'b0, ALU_A | ALU_B};
      4'b0110: sum = {1'b0, ALU_A ^ ALU_B};
      default: sum = {1'b0, ALU_A << ALU_B[4:0]};
    endcase
    ALU_RESULT = sum[31:0];
    if (ALU_ALUC[3:2] == 2'b00) begin
      ALU_CARRY    = sum[32];
      ALU_OVERFLOW = ALU_ALUC[0] ? ((ALU_A[31] != ALU_B[31]) && (sum[31] != ALU_A[31]))
                                 : ((ALU_A[31] == ALU_B[31]) && (sum[31] != ALU_A[31]));
    end
  end
  assign ALU_ZERO     = (ALU_RESULT == 32'd0);
  assign ALU_NEGATIVE = ALU_RESULT[31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction on port p with an immediate response handshake.
  task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [31:0] res, input logic [3:0] flg);
    if (p == 0) begin REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_ALUC = c; end
    else        begin REQ1_VALID = 1; REQ1_A = a; REQ1_B = b; REQ1_ALUC = c; end
    #1;
    chk($sformatf("op%0d_ready", p), {31'd0, (p == 0) ? REQ0_READY : REQ1_READY}, 32'd1);
    tick();
    REQ0_VALID = 0; REQ1_VALID = 0;
    chk($sformatf("op%0d_exec_busy", p), {31'd0, BUSY}, 32'd1);
    chk($sformatf("op%0d_exec_alu_a", p), ALU_A, a);
    chk($sformatf("op%0d_exec_novalid", p), {30'd0, RSP1_VALID, RSP0_VALID}, 32'd0);
    tick();
    chk($sformatf("op%0d_rsp_valid", p), {30'd0, RSP1_VALID, RSP0_VALID}, (p == 0) ? 32'd1 : 32'd2);
    chk($sformatf("op%0d_result", p), RSP_RESULT, res);
    chk($sformatf("op%0d_flags", p), {28'd0, RSP_FLAGS}, {28'd0, flg});
    chk($sformatf("op%0d_arch_flags", p), {28'd0, FLAG_Z, FLAG_C, FLAG_N, FLAG_V}, {28'd0, flg});
    if (p == 0) RSP0_READY = 1; else RSP1_READY = 1;
    tick();
    RSP0_READY = 0; RSP1_READY = 0;
    chk($sformatf("op%0d_idle", p), {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    RST_N = 0;
    REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 0; RSP1_READY = 0;
    REQ0_A = 0; REQ0_B = 0; REQ0_ALUC = 0;
    REQ1_A = 0; REQ1_B = 0; REQ1_ALUC = 0;
    tick();
    // Reset state
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_result", RSP_RESULT, 32'd0);
    chk("rst_flags", {24'd0, RSP_FLAGS, FLAG_Z, FLAG_C, FLAG_N, FLAG_V}, 32'd0);
    chk("rst_alu_a", ALU_A, 32'd0);
    chk("rst_valids", {28'd0, REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID}, 32'd0);
    RST_N = 1;
    tick();

    // Unsigned add with carry out: Z=1 C=1 N=0 V=0
    do_op(0, 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 4'b1100);
    // Signed add overflow: C holds 1 -> Z0 C1 N1 V1
    do_op(1, 32'h7FFF_FFFF, 32'h1, 4'b0010, 32'h8000_0000, 4'b0111);
    // AND: C and V hold -> Z1 C1 N0 V1
    do_op(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0100, 32'h0, 4'b1101);

    // Response stall on port 0 while port 1 waits (5 - 3 = 2, C=1, V holds 1)
    REQ0_VALID = 1; REQ0_A = 32'd5; REQ0_B = 32'd3; REQ0_ALUC = 4'b0001;
    tick();
    REQ0_VALID = 0;
    REQ1_VALID = 1; REQ1_A = 32'h20; REQ1_B = 32'h1; REQ1_ALUC = 4'b0000;
    RSP1_READY = 1;  // non-owner ready must be ignored
    #1;
    chk("stall_exec_req1_ready", {31'd0, REQ1_READY}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), {30'd0, RSP1_VALID, RSP0_VALID}, 32'd1);
      chk($sformatf("stall%0d_result", i), RSP_RESULT, 32'd2);
      chk($sformatf("stall%0d_flags", i), {28'd0, RSP_FLAGS}, 32'h5);
      chk($sformatf("stall%0d_req1_ready", i), {31'd0, REQ1_READY}, 32'd0);
      tick();
    end
    RSP0_READY = 1; RSP1_READY = 0;
    #1;
    chk("stall_hs_req1_ready", {31'd0, REQ1_READY}, 32'd0);
    tick();
    RSP0_READY = 0;
    chk("stall_after_req1_ready", {31'd0, REQ1_READY}, 32'd1);
    tick();
    tick();
    chk("stall_req1_rsp", {30'd0, RSP1_VALID, RSP0_VALID}, 32'd2);
    chk("stall_req1_result", RSP_RESULT, 32'h21);
    REQ1_VALID = 0; RSP1_READY = 1;
    tick();
    RSP1_READY = 0;

    // Fairness: both ports always valid, responses always taken
    REQ0_VALID = 1; REQ0_A = 32'h10; REQ0_B = 32'h1; REQ0_ALUC = 4'b0000;
    REQ1_VALID = 1; REQ1_A = 32'h20; REQ1_B = 32'h1; REQ1_ALUC = 4'b0000;
    RSP0_READY = 1; RSP1_READY = 1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr%0d_grant", k), {30'd0, REQ1_READY, REQ0_READY}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_idle", k), {31'd0, BUSY}, 32'd0);
      tick();
      chk($sformatf("rr%0d_exec", k), {31'd0, BUSY}, 32'd1);
      tick();
      chk($sformatf("rr%0d_rsp", k), {30'd0, RSP1_VALID, RSP0_VALID}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_result", k), RSP_RESULT, (k % 2 == 0) ? 32'h11 : 32'h21);
      tick();
    end
    REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 0; RSP1_READY = 0;
    tick();

    // Reset during EXEC: op discarded, flags cleared, pointer back to port 0
    REQ0_VALID = 1; REQ0_A = 32'hFFFF_FFFF; REQ0_B = 32'h1; REQ0_ALUC = 4'b0000;
    tick();
    REQ0_VALID = 0;
    chk("mid_exec_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 0;
    #1;
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_flags", {24'd0, RSP_FLAGS, FLAG_Z, FLAG_C, FLAG_N, FLAG_V}, 32'd0);
    chk("mid_rst_result", RSP_RESULT, 32'd0);
    chk("mid_rst_alu", {ALU_A[27:0], ALU_ALUC}, 32'd0);
    tick();
    RST_N = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst%0d_norsp", i), {29'd0, BUSY, RSP1_VALID, RSP0_VALID}, 32'd0);
    end
    REQ0_VALID = 1; REQ1_VALID = 1;
    #1;
    chk("post_rst_grant", {30'd0, REQ1_READY, REQ0_READY}, 32'd1);
    REQ0_VALID = 0; REQ1_VALID = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
